// File: rtl/char_buf_pkg.sv
// Shared definitions for the character-buffer reader.
// Holds the buffer geometry (12 columns x 9 rows starting at RAM word 1500),
// the line-feed code used between rows, and the reader FSM state encoding.
package char_buf_pkg;

    localparam int unsigned CHAR_BUF_BASE = 32'd1500;
    localparam int unsigned CHAR_BUF_COLS = 32'd12;
    localparam int unsigned CHAR_BUF_ROWS = 32'd9;
    localparam int unsigned CHAR_BUF_SIZE = CHAR_BUF_COLS * CHAR_BUF_ROWS;
    localparam int unsigned CHAR_BUF_ADDR_W = 32'd12;
    localparam int unsigned CHAR_IDX_W = 32'd7;

    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_PRESENT = 3'd3,
        ST_NEWLINE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/char_buf_cursor.sv
// Row/column/linear-index cursor over the character buffer.
// Ports:
//   clock, reset_n  clock and asynchronous active-low reset
//   clear           return the cursor to (row 0, col 0, idx 0)
//   advance         step to the next character; ignored on the last one
//   idx             linear character index 0..COLS*ROWS-1
//   last_col        cursor sits on the final column of a row
//   last_char       cursor sits on the final character of the buffer
module char_buf_cursor
    import char_buf_pkg::*;
#(
    parameter int unsigned COLS = CHAR_BUF_COLS,
    parameter int unsigned ROWS = CHAR_BUF_ROWS
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  advance,
    output logic [CHAR_IDX_W-1:0] idx,
    output logic                  last_col,
    output logic                  last_char
);

    localparam int unsigned COL_W = (COLS > 32'd1) ? $clog2(COLS) : 32'd1;
    localparam int unsigned ROW_W = (ROWS > 32'd1) ? $clog2(ROWS) : 32'd1;

    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;

    // Counter update: clear wins over advance; the cursor never wraps.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            col_r <= {COL_W{1'b0}};
            row_r <= {ROW_W{1'b0}};
            idx   <= {CHAR_IDX_W{1'b0}};
        end else if (clear) begin
            col_r <= {COL_W{1'b0}};
            row_r <= {ROW_W{1'b0}};
            idx   <= {CHAR_IDX_W{1'b0}};
        end else if (advance && !last_char) begin
            idx <= idx + CHAR_IDX_W'(1);
            if (last_col) begin
                col_r <= {COL_W{1'b0}};
                row_r <= row_r + ROW_W'(1);
            end else begin
                col_r <= col_r + COL_W'(1);
            end
        end else begin
            col_r <= col_r;
            row_r <= row_r;
            idx   <= idx;
        end
    end

    // Position flags decoded from the row/column registers.
    always_comb begin
        last_col  = (col_r == COL_W'(COLS - 32'd1));
        last_char = last_col && (row_r == ROW_W'(ROWS - 32'd1));
    end

endmodule

// File: rtl/char_buffer_reader.sv
// Drains the 12x9 character buffer (RAM words BASE_ADDR.., char in bits [7:0])
// out of processor RAM as a valid/ready byte stream. The RAM port is only
// used while mem_gnt is high, so the processor keeps priority.
// Optional feature: define ROW_NEWLINE_EN to emit 8'h0A after every row
// (117 bytes per dump instead of 108).
// Ports:
//   clock, reset_n          clock and asynchronous active-low reset
//   start                   pulse, begins one full-buffer dump (IDLE only)
//   busy, done              dump in progress / one-cycle completion pulse
//   mem_req, mem_gnt        RAM read-port request and grant
//   mem_addr, mem_rdata     RAM read address and 1-cycle-latency read data
//   char_data, char_valid   output byte stream
//   char_ready              downstream accept
//   char_idx                index of the character being presented
module char_buffer_reader
    import char_buf_pkg::*;
#(
    parameter int unsigned BASE_ADDR = CHAR_BUF_BASE,
    parameter int unsigned COLS      = CHAR_BUF_COLS,
    parameter int unsigned ROWS      = CHAR_BUF_ROWS,
    parameter int unsigned ADDR_W    = CHAR_BUF_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [31:0]           mem_rdata,
    output logic [7:0]            char_data,
    output logic                  char_valid,
    input  logic                  char_ready,
    output logic [CHAR_IDX_W-1:0] char_idx
);

    // The whole buffer must fit inside the RAM address space and the index.
    if ((BASE_ADDR + COLS * ROWS - 32'd1) >= (32'd1 << ADDR_W)) begin : g_addr_range_check
        $error("char_buffer_reader: buffer end address exceeds ADDR_W");
    end
    if ((COLS * ROWS) > (32'd1 << CHAR_IDX_W)) begin : g_idx_range_check
        $error("char_buffer_reader: buffer size exceeds char_idx range");
    end

    state_t            state_r;
    logic              accept_s;
    logic              clear_s;
    logic              advance_s;
    logic              last_col_s;
    logic              last_char_s;
    logic [ADDR_W-1:0] next_addr_s;
    logic [23:0]       unused_rdata_hi;

    // Only the low byte of a RAM word carries the character.
    assign unused_rdata_hi = mem_rdata[31:8];

    char_buf_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (clear_s),
        .advance   (advance_s),
        .idx       (char_idx),
        .last_col  (last_col_s),
        .last_char (last_char_s)
    );

`ifdef ROW_NEWLINE_EN
    localparam bit NEWLINE_EN = 1'b1;
`else
    localparam bit NEWLINE_EN = 1'b0;
    logic unused_last_col;
    assign unused_last_col = last_col_s;
`endif

    // Cursor control: clear on an accepted start; step when the byte that
    // ends a character slot is accepted (the row LF shares its char's index).
    always_comb begin
        accept_s    = char_valid && char_ready;
        clear_s     = 1'b0;
        advance_s   = 1'b0;
        next_addr_s = ADDR_W'(BASE_ADDR) + ADDR_W'(char_idx) + ADDR_W'(1);
        case (state_r)
            ST_IDLE: begin
                clear_s = start;
            end
            ST_PRESENT: begin
                if (NEWLINE_EN && last_col_s) begin
                    advance_s = 1'b0;
                end else begin
                    advance_s = accept_s && !last_char_s;
                end
            end
            ST_NEWLINE: begin
                advance_s = accept_s && !last_char_s;
            end
            default: begin
                clear_s   = 1'b0;
                advance_s = 1'b0;
            end
        endcase
    end

    // Reader FSM with registered RAM-interface and stream outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= ADDR_W'(BASE_ADDR);
            char_valid <= 1'b0;
            char_data  <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r  <= ST_ISSUE;
                        busy     <= 1'b1;
                        mem_req  <= 1'b1;
                        mem_addr <= ADDR_W'(BASE_ADDR);
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // Wait indefinitely for the port; address stays put.
                    if (mem_gnt) begin
                        state_r <= ST_CAPTURE;
                        mem_req <= 1'b0;
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_CAPTURE: begin
                    char_data  <= mem_rdata[7:0];
                    char_valid <= 1'b1;
                    state_r    <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (accept_s) begin
                        if (NEWLINE_EN && last_col_s) begin
                            char_data  <= ASCII_LF;
                            char_valid <= 1'b1;
                            state_r    <= ST_NEWLINE;
                        end else if (last_char_s) begin
                            char_valid <= 1'b0;
                            done       <= 1'b1;
                            state_r    <= ST_DONE;
                        end else begin
                            char_valid <= 1'b0;
                            mem_req    <= 1'b1;
                            mem_addr   <= next_addr_s;
                            state_r    <= ST_ISSUE;
                        end
                    end else begin
                        state_r <= ST_PRESENT;
                    end
                end
                ST_NEWLINE: begin
                    if (accept_s) begin
                        char_valid <= 1'b0;
                        if (last_char_s) begin
                            done    <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= next_addr_s;
                            state_r  <= ST_ISSUE;
                        end
                    end else begin
                        state_r <= ST_NEWLINE;
                    end
                end
                ST_DONE: begin
                    // A start seen here is dropped; only IDLE accepts one.
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    mem_req    <= 1'b0;
                    char_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_char_buffer_reader.sv
// Scoreboard bench for char_buffer_reader: stimulus pushes the expected
// byte stream, a negedge monitor pops and compares each accepted byte.
module tb_char_buffer_reader;

    typedef struct packed {
        logic [6:0] idx;
        logic [7:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        mem_req;
    logic        mem_gnt = 1'b1;
    logic [11:0] mem_addr;
    logic [31:0] mem_rdata = 32'h0;
    logic [7:0]  char_data;
    logic        char_valid;
    logic        char_ready;
    logic [6:0]  char_idx;

    logic [31:0] ram [0:4095];
    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          rd_cnt = 0;
    int          done_cnt = 0;
    bit          rand_ready = 1'b0;

`ifdef ROW_NEWLINE_EN
    localparam int DUMP_BYTES = 117;
`else
    localparam int DUMP_BYTES = 108;
`endif

    char_buffer_reader dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .char_data  (char_data),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .char_idx   (char_idx)
    );

    always #5 clock = ~clock;

    // Synchronous-read RAM model and granted-read counter
    always @(posedge clock) begin
        mem_rdata <= ram[mem_addr];
        if (reset_n && mem_req && mem_gnt) rd_cnt <= rd_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int kind, input int i);
        logic [7:0] b;
        if (kind == 0) b = 8'(i + 32'h20);
        else b = 8'(i * 37);
        return b;
    endfunction

    task automatic load_ram(input int kind);
        for (int a = 0; a < 4096; a++) ram[a] = 32'hDEAD_00EE;
        for (int i = 0; i < 108; i++) ram[1500 + i] = {24'hA5C396 ^ 24'(i), exp_byte(kind, i)};
    endtask

    task automatic push_dump(input int kind);
        exp_t e;
        for (int i = 0; i < 108; i++) begin
            e.idx = 7'(i);
            e.data = exp_byte(kind, i);
            exp_q.push_back(e);
`ifdef ROW_NEWLINE_EN
            if ((i % 12) == 11) begin
                e.data = 8'h0A;
                exp_q.push_back(e);
            end
`endif
        end
    endtask

    // Ready driver: changes just after each posedge
    initial begin
        char_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            char_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: stability while stalled, scoreboard pop on accept, done count
    initial begin
        bit         stall_prev = 1'b0;
        logic [7:0] hold_data = 8'h0;
        logic [6:0] hold_idx = 7'h0;
        exp_t       e;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                stall_prev = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (stall_prev) begin
                    check("stall_valid", 32'(char_valid), 32'd1);
                    check("stall_data", 32'(char_data), 32'(hold_data));
                    check("stall_idx", 32'(char_idx), 32'(hold_idx));
                end
                if (char_valid && char_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", 32'(char_data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte_data", 32'(char_data), 32'(e.data));
                        check("byte_idx", 32'(char_idx), 32'(e.idx));
                    end
                end
                stall_prev = char_valid && !char_ready;
                hold_data = char_data;
                hold_idx = char_idx;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idx(input int target);
        bit hit = 1'b0;
        for (int c = 0; c < 4000 && !hit; c++) begin
            @(negedge clock);
            if (char_valid && (int'(char_idx) == target)) hit = 1'b1;
        end
        if (!hit) check("wait_idx_timeout", 32'd0, 32'd1);
    endtask

    // Wait for done, then check the end-of-dump bookkeeping
    task automatic finish_dump(input string tag, input int rd0, input int dn0, input bit start_on_done);
        bit hit = 1'b0;
        for (int c = 0; c < 6000 && !hit; c++) begin
            @(negedge clock);
            if (done) hit = 1'b1;
        end
        if (!hit) check({tag, "_done_timeout"}, 32'd0, 32'd1);
        if (start_on_done) begin
            start = 1'b1;
            @(posedge clock);
            #1;
            start = 1'b0;
        end
        @(negedge clock);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        @(negedge clock);
        check({tag, "_done_count"}, 32'(done_cnt - dn0), 32'd1);
        check({tag, "_ram_reads"}, 32'(rd_cnt - rd0), 32'd108);
        check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_idle_no_req"}, 32'(mem_req), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0;
        int dn0;
        load_ram(0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_valid", 32'(char_valid), 32'd0);
        check("rst_data", 32'(char_data), 32'd0);
        check("rst_idx", 32'(char_idx), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd1500);

        // 1: straight dump, latency and throughput
        rd0 = rd_cnt; dn0 = done_cnt;
        push_dump(0);
        pulse_start();
        @(negedge clock);
        check("lat_req_n1", 32'(mem_req), 32'd1);
        check("lat_addr_n1", 32'(mem_addr), 32'd1500);
        check("lat_busy_n1", 32'(busy), 32'd1);
        check("lat_valid_n1", 32'(char_valid), 32'd0);
        @(negedge clock);
        check("lat_req_n2", 32'(mem_req), 32'd0);
        @(negedge clock);
        check("lat_valid_n3", 32'(char_valid), 32'd1);
        @(negedge clock);
        check("tput_req_n4", 32'(mem_req), 32'd1);
        check("tput_addr_n4", 32'(mem_addr), 32'd1501);
        finish_dump("t1", rd0, dn0, 1'b0);

        // 2: random ready, data includes 0x00
        load_ram(1);
        rand_ready = 1'b1;
        rd0 = rd_cnt; dn0 = done_cnt;
        push_dump(1);
        pulse_start();
        finish_dump("t2", rd0, dn0, 1'b0);
        rand_ready = 1'b0;

        // 3: grant withheld for 20 cycles in ISSUE
        @(negedge clock);
        mem_gnt = 1'b0;
        rd0 = rd_cnt; dn0 = done_cnt;
        push_dump(1);
        pulse_start();
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            check("nognt_req", 32'(mem_req), 32'd1);
            check("nognt_addr", 32'(mem_addr), 32'd1500);
            check("nognt_valid", 32'(char_valid), 32'd0);
        end
        mem_gnt = 1'b1;
        finish_dump("t3", rd0, dn0, 1'b0);

        // 4: start while busy, then start coincident with done
        rd0 = rd_cnt; dn0 = done_cnt;
        push_dump(1);
        pulse_start();
        wait_idx(50);
        pulse_start();
        finish_dump("t4", rd0, dn0, 1'b1);
        repeat (4) begin
            @(negedge clock);
            check("t4_start_on_done_ignored", 32'(busy), 32'd0);
        end

        // 5: reset mid-dump, then replay from index 0
        push_dump(0);
        load_ram(0);
        pulse_start();
        wait_idx(30);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_valid", 32'(char_valid), 32'd0);
        check("arst_data", 32'(char_data), 32'd0);
        check("arst_idx", 32'(char_idx), 32'd0);
        check("arst_req", 32'(mem_req), 32'd0);
        check("arst_addr", 32'(mem_addr), 32'd1500);
        exp_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        rd0 = rd_cnt; dn0 = done_cnt;
        push_dump(0);
        pulse_start();
        @(negedge clock);
        check("replay_addr", 32'(mem_addr), 32'd1500);
        check("replay_req", 32'(mem_req), 32'd1);
        finish_dump("t5", rd0, dn0, 1'b0);

        check("dump_bytes_const", 32'(DUMP_BYTES), (rd_cnt > 0) ? 32'(DUMP_BYTES) : 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
